// File: rtl/log_alu_pkg.sv
// Shared constants for the float log2 unit: IEEE-754 single field layout,
// exponent bias, FSM state type and the special-operand classifier.
package log_alu_pkg;

  localparam int FLT_W        = 32;
  localparam int FLT_EXP_W    = 8;
  localparam int FLT_MAN_W    = 23;
  localparam int FLT_SIGN_POS = 31;
  localparam int FLT_EXP_MSB  = 30;
  localparam int FLT_EXP_LSB  = 23;
  localparam int FLT_MAN_MSB  = 22;
  localparam int FLT_EXP_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } log_state_e;

  // Zero/denormal wins over inf/NaN, which wins over a negative sign.
  function automatic logic flt_is_special(input logic [FLT_W-1:0] flt);
    logic [FLT_EXP_W-1:0] exp_v;
    exp_v = flt[FLT_EXP_MSB:FLT_EXP_LSB];
    if (exp_v == 8'h00) begin
      return 1'b1;
    end else if (exp_v == 8'hFF) begin
      return 1'b1;
    end else begin
      return flt[FLT_SIGN_POS];
    end
  endfunction

endpackage

// File: rtl/log2_frac_step.sv
// One fraction bit of log2 by repeated squaring: y in [1,2) is squared and
// renormalised back into [1,2); the renormalising shift is the next bit.
module log2_frac_step
  import log_alu_pkg::*;
(
  input  logic [FLT_MAN_W:0] y,
  output logic [FLT_MAN_W:0] y_next,
  output logic               frac_bit
);

  logic [24:0] p_hi_s;

  // Only p[47:23] matters: either p[47:24] or p[46:23] survives truncation.
  always_comb begin
    p_hi_s = 25'((48'(y) * 48'(y)) >> 23);
    if (p_hi_s[24]) begin
      frac_bit = 1'b1;
      y_next   = p_hi_s[24:1];
    end else begin
      frac_bit = 1'b0;
      y_next   = p_hi_s[23:0];
    end
  end

endmodule

// File: rtl/float_log2_seq.sv
// Sequential log2 of an IEEE-754 single, one fraction bit per clock, Q8.FRAC_BITS out.
// Define FLOAT_LOG2_ROUND_EN for a guard cycle and round-half-up (default: truncate).
module float_log2_seq
  import log_alu_pkg::*;
#(
  parameter int FRAC_BITS = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLT_W-1:0]       in_flt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8+FRAC_BITS-1:0] out_log,
  output logic                   out_err
);

`ifdef FLOAT_LOG2_ROUND_EN
  localparam int ACC_BITS = FRAC_BITS + 1;
`else
  localparam int ACC_BITS = FRAC_BITS;
`endif
  localparam int         OUT_W    = 8 + FRAC_BITS;
  localparam logic [4:0] LAST_CNT = 5'(ACC_BITS - 1);

  log_state_e          state_r;
  logic [7:0]          int_r;
  logic [FLT_MAN_W:0]  y_r;
  logic [FLT_MAN_W:0]  y_next_s;
  logic [ACC_BITS-1:0] frac_r;
  logic [ACC_BITS-1:0] frac_next_s;
  logic [4:0]          cnt_r;
  logic                err_r;
  logic                bit_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                out_err_r;
  logic [OUT_W-1:0]    out_log_r;
  logic [OUT_W-1:0]    result_s;
  logic                accept_s;
`ifdef FLOAT_LOG2_ROUND_EN
  logic [OUT_W-1:0]    sum_s;
`endif

  log2_frac_step u_step (
    .y        (y_r),
    .y_next   (y_next_s),
    .frac_bit (bit_s)
  );

  assign in_ready    = in_ready_r & ~rst;
  assign accept_s    = in_valid & in_ready;
  assign frac_next_s = ACC_BITS'({frac_r, bit_s});
  assign out_valid   = out_valid_r;
  assign out_log     = out_log_r;
  assign out_err     = out_err_r;

  // Final value assembled from the integer part and the fraction including this cycle's bit.
  always_comb begin
    result_s = '0;
`ifdef FLOAT_LOG2_ROUND_EN
    sum_s = {int_r, frac_next_s[ACC_BITS-1:1]} + OUT_W'(frac_next_s[0]);
    if (!int_r[7] && sum_s[OUT_W-1]) begin
      result_s = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      result_s = sum_s;
    end
`else
    result_s = {int_r, frac_next_s};
`endif
  end

  // Control FSM, iteration counter, datapath registers and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      int_r       <= 8'h00;
      y_r         <= '0;
      frac_r      <= '0;
      cnt_r       <= 5'd0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_log_r   <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            int_r      <= in_flt[FLT_EXP_MSB:FLT_EXP_LSB] - 8'(FLT_EXP_BIAS);
            y_r        <= {1'b1, in_flt[FLT_MAN_MSB:0]};
            frac_r     <= '0;
            cnt_r      <= 5'd0;
            err_r      <= flt_is_special(in_flt);
            in_ready_r <= 1'b0;
            state_r    <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // A special operand spends only this one cycle here, never iterating.
          if (err_r) begin
            out_log_r   <= '0;
            out_err_r   <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            y_r    <= y_next_s;
            frac_r <= frac_next_s;
            cnt_r  <= cnt_r + 5'd1;
            if (cnt_r == LAST_CNT) begin
              out_log_r   <= result_s;
              out_err_r   <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_log2_seq.sv
// Directed self-checking bench for float_log2_seq at FRAC_BITS=23, truncating build.
// Latency is counted as the cycle index after the accept edge k (first cycle after edge k is k+1).
module tb_float_log2_seq;
  localparam int FB = 23;
  localparam int OW = 8 + FB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_flt;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_log;
  logic          out_err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  float_log2_seq #(.FRAC_BITS(FB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flt    (in_flt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log   (out_log),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with in_ready high; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [31:0] flt, output logic [OW-1:0] log_o,
                        output logic err_o, output int lat_o);
    int n;
    in_valid = 1'b1;
    in_flt   = flt;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    log_o = out_log;
    err_o = out_err;
    lat_o = n;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [OW-1:0] r_log;
  logic          r_err;
  int            r_lat;
  logic [31:0]   specials [4];
  logic          seen;

  initial begin
    specials[0] = 32'h0000_0000;
    specials[1] = 32'hBF80_0000;
    specials[2] = 32'h7F80_0000;
    specials[3] = 32'h7FC0_0000;

    rst = 1'b1; in_valid = 1'b0; in_flt = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_log", 64'(out_log), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    run_op(32'h3F80_0000, r_log, r_err, r_lat);
    check("one_log", 64'(r_log), 64'd0);
    check("one_err", 64'(r_err), 64'd0);
    check("one_lat", 64'(r_lat), 64'd24);
    take();

    run_op(32'h3F00_0000, r_log, r_err, r_lat);
    check("half_log", 64'(r_log), 64'h7F80_0000);
    check("half_err", 64'(r_err), 64'd0);
    take();

    run_op(32'h4040_0000, r_log, r_err, r_lat);
    check("three_int", 64'(r_log[OW-1:FB]), 64'd1);
    check("three_frac_range",
          64'((r_log[FB-1:0] >= 23'd4907019) && (r_log[FB-1:0] <= 23'd4907021)), 64'd1);
    check("three_err", 64'(r_err), 64'd0);
    take();

    run_op(32'h0080_0000, r_log, r_err, r_lat);
    check("min_normal_log", 64'(r_log), 64'h4100_0000);
    take();
    run_op(32'h7F00_0000, r_log, r_err, r_lat);
    check("max_pow2_log", 64'(r_log), 64'h3F80_0000);
    take();

    for (int i = 0; i < 4; i++) begin
      run_op(specials[i], r_log, r_err, r_lat);
      check($sformatf("special%0d_err", i), 64'(r_err), 64'd1);
      check($sformatf("special%0d_log", i), 64'(r_log), 64'd0);
      check($sformatf("special%0d_lat", i), 64'(r_lat), 64'd2);
      take();
    end

    // Result held in DONE with the consumer stalled.
    run_op(32'h4100_0000, r_log, r_err, r_lat);
    check("eight_log", 64'(r_log), 64'h0180_0000);
    check("eight_lat", 64'(r_lat), 64'd24);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_log", i), 64'(out_log), 64'h0180_0000);
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("take_cycle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check("after_take_valid", 64'(out_valid), 64'd0);
    check("after_take_in_ready", 64'(in_ready), 64'd1);

    // Abort a calculation with a reset pulse sampled at edge k+10.
    in_valid = 1'b1;
    in_flt   = 32'h4040_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    run_op(32'h4100_0000, r_log, r_err, r_lat);
    check("post_abort_log", 64'(r_log), 64'h0180_0000);
    check("post_abort_err", 64'(r_err), 64'd0);
    take();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
